// File: rtl/pdm_mic_controller.sv
// rtl/pdm_mic_controller.sv - PDM microphone clocking, wake/settle sequencing and PCM word framing
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable            level, 1 = run the microphone
//   mic_clk, mic_data microphone clock out, PDM data in
//   dec_pdm(_valid)   sampled PDM bit and its one-cycle strobe to the decimator
//   dec_pcm           decimator PCM result, captured at the frame boundary
//   pcm, pcm_valid, pcm_ready  PCM word output handshake
//   overrun           sticky flag, a captured word was dropped
//   overrun_count     saturating drop counter (only with OVERRUN_COUNT_EN)
//   busy              controller not idle
//
// Optional feature macro: OVERRUN_COUNT_EN
module pdm_mic_controller #(
    parameter int CLK_DIV         = 25,
    parameter int DECIMATION      = 64,
    parameter int WAKE_PERIODS    = 4096,
    parameter int STARTUP_SAMPLES = 16,
    parameter int CAPTURE_DELAY   = 2,
    parameter int PCM_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 mic_clk,
    input  logic                 mic_data,
    output logic                 dec_pdm,
    output logic                 dec_pdm_valid,
    input  logic [PCM_WIDTH-1:0] dec_pcm,
    output logic [PCM_WIDTH-1:0] pcm,
    output logic                 pcm_valid,
    input  logic                 pcm_ready,
    output logic                 overrun,
`ifdef OVERRUN_COUNT_EN
    output logic [7:0]           overrun_count,
`endif
    output logic                 busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int WW = $clog2(WAKE_PERIODS + 1);
    localparam int FW = $clog2(DECIMATION + 1);
    localparam int SW = $clog2(STARTUP_SAMPLES + 2);

    typedef enum logic [2:0] {IDLE, WAKE, SETTLE, RUN, STOP} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [WW-1:0] wake_cnt;
    logic [FW-1:0] frame_cnt;
    logic [SW-1:0] settle_cnt;
    logic [2:0]    cap_cnt;

    logic div_wrap;
    logic fall;
    logic cap_now;
    logic xfer;

    assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
    assign fall     = div_wrap && mic_clk;
    // cap_cnt is loaded with the delay and counts down; the capture lands on the edge where it reads 1
    assign cap_now  = (cap_cnt == 3'd1);
    assign xfer     = pcm_valid && pcm_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            div_cnt       <= '0;
            wake_cnt      <= '0;
            frame_cnt     <= '0;
            settle_cnt    <= '0;
            cap_cnt       <= '0;
            mic_clk       <= 1'b0;
            dec_pdm       <= 1'b0;
            dec_pdm_valid <= 1'b0;
            pcm           <= '0;
            pcm_valid     <= 1'b0;
            overrun       <= 1'b0;
`ifdef OVERRUN_COUNT_EN
            overrun_count <= '0;
`endif
        end else begin
            dec_pdm_valid <= 1'b0;
            // A held word stays available through STOP/IDLE until the consumer takes it
            if (xfer) begin
                pcm_valid <= 1'b0;
            end
            if (cap_cnt != 3'd0) begin
                cap_cnt <= cap_cnt - 3'd1;
            end
            if (state != IDLE) begin
                if (div_wrap) begin
                    div_cnt <= '0;
                    mic_clk <= ~mic_clk;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    mic_clk <= 1'b0;
                    if (enable) begin
                        state   <= WAKE;
                        overrun <= 1'b0;
`ifdef OVERRUN_COUNT_EN
                        overrun_count <= '0;
`endif
                    end
                end
                WAKE, SETTLE, RUN: begin
                    if (!enable) begin
                        state      <= STOP;
                        cap_cnt    <= '0;
                        frame_cnt  <= '0;
                        wake_cnt   <= '0;
                        settle_cnt <= '0;
                    end else begin
                        if (fall) begin
                            if (state == WAKE) begin
                                if (wake_cnt == WW'(WAKE_PERIODS - 1)) begin
                                    state     <= (STARTUP_SAMPLES == 0) ? RUN : SETTLE;
                                    frame_cnt <= '0;
                                end else begin
                                    wake_cnt <= wake_cnt + WW'(1);
                                end
                            end else begin
                                dec_pdm       <= mic_data;
                                dec_pdm_valid <= 1'b1;
                                if (frame_cnt == FW'(DECIMATION - 1)) begin
                                    frame_cnt <= '0;
                                    cap_cnt   <= 3'(CAPTURE_DELAY);
                                end else begin
                                    frame_cnt <= frame_cnt + FW'(1);
                                end
                            end
                        end
                        if (cap_now) begin
                            if (state == SETTLE) begin
                                if (settle_cnt == SW'(STARTUP_SAMPLES - 1)) begin
                                    state <= RUN;
                                end else begin
                                    settle_cnt <= settle_cnt + SW'(1);
                                end
                            end else if (state == RUN) begin
                                // Loading is allowed when the slot is empty or being emptied this cycle
                                if (!pcm_valid || pcm_ready) begin
                                    pcm       <= dec_pcm;
                                    pcm_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
`ifdef OVERRUN_COUNT_EN
                                    if (overrun_count != 8'hFF) begin
                                        overrun_count <= overrun_count + 8'd1;
                                    end
`endif
                                end
                            end
                        end
                    end
                end
                STOP: begin
                    // Leave only at a divider wrap so the last mic_clk high phase is full width
                    if (div_wrap) begin
                        mic_clk <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
